alu_entry_fsm: RTL and testbench

Operand/opcode entry controller sitting directly downstream of the push-button debouncers and upstream of the ALU. It converts the debounced ENTER and CLEAR levels into single-cycle rising-edge events. It steps through a load sequence (operand A, operand B, opcode) sampling the board switches, then issues a one-cycle start to the ALU and waits for completion. A cycle-count watchdog bounds the wait.

---
 rtl/alu_entry_pkg.sv | 19 +
 rtl/rise_pulse.sv | 34 +++
 rtl/alu_entry_fsm.sv | 161 ++++++++++++++++
 tb/tb_alu_entry_fsm.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_entry_pkg.sv
// alu_entry_pkg
// Shared definitions for the operand/opcode entry controller:
//   - state_t : FSM state encoding, also driven onto the LED state port
//   - DEF_*   : default operand width, opcode width and watchdog limit
package alu_entry_pkg;

    typedef enum logic [2:0] {
        ST_LOAD_A  = 3'd0,
        ST_LOAD_B  = 3'd1,
        ST_LOAD_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SHOW    = 3'd4
    } state_t;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_OPW     = 3;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/rise_pulse.sv
// rise_pulse
// Turns a synchronized, debounced button level into a one-cycle pulse on
// its rising edge.
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   level in  debounced button level
//   pulse out high for one cycle when level goes 0 -> 1
// The history flop resets to 1 so a button held through reset produces no
// pulse until it has been released and pressed again.
module rise_pulse (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic hist_q;
    logic hist_d;

    always_comb begin
        hist_d = level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign pulse = level & ~hist_q;

endmodule

// File: rtl/alu_entry_fsm.sv
// alu_entry_fsm
// Operand/opcode entry controller between the push-button debouncers and
// the ALU. ENTER presses step through A, B and opcode loads from the
// switches, then a one-cycle start is issued and the controller waits for
// alu_done, bounded by a cycle-count watchdog. CLEAR returns to the start
// and zeroes all entered values.
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   btn_enter   in   debounced ENTER level
//   btn_clear   in   debounced CLEAR level
//   sw          in   WIDTH switch value, sampled on ENTER
//   alu_done    in   ALU completion strobe (only honoured in EXEC)
//   op_a        out  WIDTH registered operand A
//   op_b        out  WIDTH registered operand B
//   opcode      out  OPW registered opcode (low bits of sw)
//   start       out  one-cycle ALU start, first EXEC cycle
//   state       out  current state code for LEDs
//   timeout_err out  sticky watchdog-expiry flag
module alu_entry_fsm
    import alu_entry_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int OPW     = DEF_OPW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_enter,
    input  logic             btn_clear,
    input  logic [WIDTH-1:0] sw,
    input  logic             alu_done,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [OPW-1:0]   opcode,
    output logic             start,
    output logic [2:0]       state,
    output logic             timeout_err
);

    localparam int             WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic enter_rise;
    logic clear_rise;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] op_a_q,   op_a_d;
    logic [WIDTH-1:0] op_b_q,   op_b_d;
    logic [OPW-1:0]   opcode_q, opcode_d;
    logic             start_q,  start_d;
    logic             err_q,    err_d;
    logic [WD_W-1:0]  wd_q,     wd_d;

    rise_pulse u_enter_rise (
        .clk   (clk),
        .rst   (rst),
        .level (btn_enter),
        .pulse (enter_rise)
    );

    rise_pulse u_clear_rise (
        .clk   (clk),
        .rst   (rst),
        .level (btn_clear),
        .pulse (clear_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_LOAD_A;
            op_a_q   <= '0;
            op_b_q   <= '0;
            opcode_q <= '0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            opcode_q <= opcode_d;
            start_q  <= start_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        opcode_d = opcode_q;
        start_d  = 1'b0;   // start is only ever a single-cycle pulse
        err_d    = err_q;
        wd_d     = wd_q;

        if (clear_rise) begin
            // CLEAR outranks any simultaneous ENTER or alu_done.
            state_d  = ST_LOAD_A;
            op_a_d   = '0;
            op_b_d   = '0;
            opcode_d = '0;
            err_d    = 1'b0;
            wd_d     = '0;
        end else begin
            case (state_q)
                ST_LOAD_A: begin
                    if (enter_rise) begin
                        op_a_d  = sw;
                        state_d = ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (enter_rise) begin
                        op_b_d  = sw;
                        state_d = ST_LOAD_OP;
                    end
                end
                ST_LOAD_OP: begin
                    if (enter_rise) begin
                        opcode_d = sw[OPW-1:0];
                        state_d  = ST_EXEC;
                        start_d  = 1'b1;
                        wd_d     = '0;
                        err_d    = 1'b0;
                    end
                end
                ST_EXEC: begin
                    // wd_q counts EXEC cycles already spent; expiry on the
                    // TIMEOUT-th cycle makes SHOW appear exactly TIMEOUT
                    // cycles after the start cycle. Completion wins a tie.
                    if (alu_done) begin
                        state_d = ST_SHOW;
                    end else if (wd_q == WD_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_SHOW;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (enter_rise) begin
                        state_d = ST_LOAD_A;
                    end
                end
                default: begin
                    // Unused codes 5..7 fall back to the entry point.
                    state_d = ST_LOAD_A;
                end
            endcase
        end
    end

    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign opcode      = opcode_q;
    assign start       = start_q;
    assign state       = state_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_alu_entry_fsm.sv
module tb_alu_entry_fsm;

    localparam int WIDTH = 4;
    localparam int OPW   = 3;
    localparam int TO    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             btn_enter;
    logic             btn_clear;
    logic [WIDTH-1:0] sw;
    logic             alu_done;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [OPW-1:0]   opcode;
    logic             start;
    logic [2:0]       state;
    logic             timeout_err;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: state as a plain number, EXEC time measured in
    // elapsed cycles since the start cycle.
    int m_state;
    int m_a, m_b, m_op;
    int m_start, m_err;
    int m_exec_cycles;
    int m_prev_enter, m_prev_clear;

    alu_entry_fsm #(
        .WIDTH   (WIDTH),
        .OPW     (OPW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_enter   (btn_enter),
        .btn_clear   (btn_clear),
        .sw          (sw),
        .alu_done    (alu_done),
        .op_a        (op_a),
        .op_b        (op_b),
        .opcode      (opcode),
        .start       (start),
        .state       (state),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        int er, cr, nstart;
        if (rst) begin
            m_state = 0; m_a = 0; m_b = 0; m_op = 0;
            m_start = 0; m_err = 0; m_exec_cycles = 0;
            m_prev_enter = 1; m_prev_clear = 1;
            return;
        end
        er = (btn_enter && !m_prev_enter) ? 1 : 0;
        cr = (btn_clear && !m_prev_clear) ? 1 : 0;
        m_prev_enter = btn_enter ? 1 : 0;
        m_prev_clear = btn_clear ? 1 : 0;
        nstart = 0;
        if (cr) begin
            m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_err = 0;
        end else if (m_state == 0) begin
            if (er) begin m_a = int'(sw); m_state = 1; end
        end else if (m_state == 1) begin
            if (er) begin m_b = int'(sw); m_state = 2; end
        end else if (m_state == 2) begin
            if (er) begin
                m_op = int'(sw) % 8; m_state = 3; nstart = 1;
                m_exec_cycles = 0; m_err = 0;
            end
        end else if (m_state == 3) begin
            m_exec_cycles++;
            if (alu_done) m_state = 4;
            else if (m_exec_cycles == TO) begin m_err = 1; m_state = 4; end
        end else begin
            if (er) m_state = 0;
        end
        m_start = nstart;
    endtask

    // One clock: model follows the DUT edge, outputs settle, then inputs may change.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic press_enter(input logic [WIDTH-1:0] v);
        sw = v; btn_enter = 1'b1; step();
        btn_enter = 1'b0; step();
    endtask

    task automatic press_clear();
        btn_clear = 1'b1; step();
        btn_clear = 1'b0; step();
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_enter = 1'b1; btn_clear = 1'b0; alu_done = 1'b0; sw = 4'hA;
        step(); step();
        rst = 1'b0;
        n_checks++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
        n_checks++; if (op_a !== 4'd0) begin n_err++; $display("FAIL reset_op_a got %0h want 0", op_a); end
        n_checks++; if (op_b !== 4'd0) begin n_err++; $display("FAIL reset_op_b got %0h want 0", op_b); end
        n_checks++; if (opcode !== 3'd0) begin n_err++; $display("FAIL reset_opcode got %0h want 0", opcode); end
        n_checks++; if (start !== 1'b0) begin n_err++; $display("FAIL reset_start got %0b want 0", start); end
        n_checks++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %0b want 0", timeout_err); end
        step(); step(); step();
        n_checks++; if (state !== 3'd0) begin n_err++; $display("FAIL held_through_reset got %0d want 0", state); end
        btn_enter = 1'b0; step(); step(); step();
        btn_enter = 1'b1; step();
        n_checks++; if (state !== 3'd1) begin n_err++; $display("FAIL first_press_state got %0d want 1", state); end
        n_checks++; if (op_a !== 4'hA) begin n_err++; $display("FAIL first_press_op_a got %0h want a", op_a); end
        btn_enter = 1'b0; step();
        press_clear();
        n_checks++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_clear got %0d want 0", state); end
    endtask

    task automatic test_full_sequence();
        press_enter(4'h5);
        press_enter(4'h3);
        sw = 4'b1010; btn_enter = 1'b1; step();
        n_checks++; if (start !== 1'b1) begin n_err++; $display("FAIL seq_start_hi got %0b want 1", start); end
        n_checks++; if (state !== 3'd3) begin n_err++; $display("FAIL seq_exec got %0d want 3", state); end
        btn_enter = 1'b0; step();
        n_checks++; if (start !== 1'b0) begin n_err++; $display("FAIL seq_start_lo got %0b want 0", start); end
        step();
        n_checks++; if (state !== 3'd3) begin n_err++; $display("FAIL seq_wait got %0d want 3", state); end
        alu_done = 1'b1; step(); alu_done = 1'b0;
        n_checks++; if (state !== 3'd4) begin n_err++; $display("FAIL seq_show got %0d want 4", state); end
        n_checks++; if (op_a !== 4'h5) begin n_err++; $display("FAIL seq_op_a got %0h want 5", op_a); end
        n_checks++; if (op_b !== 4'h3) begin n_err++; $display("FAIL seq_op_b got %0h want 3", op_b); end
        n_checks++; if (opcode !== 3'd2) begin n_err++; $display("FAIL seq_opcode got %0h want 2", opcode); end
        n_checks++; if (start !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL seq_flags got %0b%0b want 00", start, timeout_err); end
        press_enter(4'h0);
        n_checks++; if (state !== 3'd0 || op_a !== 4'h5) begin n_err++; $display("FAIL seq_return got %0d/%0h want 0/5", state, op_a); end
        press_clear();
    endtask

    task automatic test_hold_enter();
        logic [WIDTH-1:0] v;
        int bad;
        v = WIDTH'($urandom_range(0, 15));
        bad = 0;
        sw = v; btn_enter = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (state !== 3'd1) bad++;
        end
        btn_enter = 1'b0; step();
        n_checks++; if (bad != 0) begin n_err++; $display("FAIL hold_cycles got %0d bad want 0", bad); end
        n_checks++; if (state !== 3'd1 || op_a !== v) begin n_err++; $display("FAIL hold_final got %0d/%0h want 1/%0h", state, op_a, v); end
        press_clear();
    endtask

    task automatic test_timeout();
        int early;
        press_enter(WIDTH'($urandom_range(0, 15)));
        press_enter(WIDTH'($urandom_range(0, 15)));
        sw = WIDTH'($urandom_range(0, 15)); btn_enter = 1'b1; step();
        btn_enter = 1'b0;
        early = 0;
        for (int i = 1; i < TO; i++) begin
            step();
            if (state !== 3'd3 || timeout_err !== 1'b0) early++;
        end
        n_checks++; if (early != 0) begin n_err++; $display("FAIL timeout_early got %0d bad want 0", early); end
        step();
        n_checks++; if (state !== 3'd4) begin n_err++; $display("FAIL timeout_state got %0d want 4", state); end
        n_checks++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL timeout_err got %0b want 1", timeout_err); end
        press_clear();
        n_checks++; if (state !== 3'd0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL timeout_clear got %0d/%0b want 0/0", state, timeout_err); end
        n_checks++; if (op_a !== 4'd0 || op_b !== 4'd0 || opcode !== 3'd0) begin n_err++; $display("FAIL timeout_clear_ops got %0h %0h %0h want 0 0 0", op_a, op_b, opcode); end
    endtask

    task automatic test_enter_clear_same();
        press_enter(4'h9);
        sw = 4'h7; btn_enter = 1'b1; btn_clear = 1'b1; step();
        btn_enter = 1'b0; btn_clear = 1'b0;
        n_checks++; if (state !== 3'd0) begin n_err++; $display("FAIL same_cycle_state got %0d want 0", state); end
        n_checks++; if (op_b !== 4'd0 || op_a !== 4'd0) begin n_err++; $display("FAIL same_cycle_ops got %0h/%0h want 0/0", op_a, op_b); end
        step();
    endtask

    task automatic test_done_with_start();
        press_enter(4'h1);
        press_enter(4'h2);
        sw = 4'h6; btn_enter = 1'b1; step();
        btn_enter = 1'b0; alu_done = 1'b1;
        n_checks++; if (start !== 1'b1) begin n_err++; $display("FAIL dws_start got %0b want 1", start); end
        step(); alu_done = 1'b0;
        n_checks++; if (state !== 3'd4 || opcode !== 3'd6) begin n_err++; $display("FAIL dws_show got %0d/%0h want 4/6", state, opcode); end
        press_enter(4'h0);
        alu_done = 1'b1; step(); step(); step(); alu_done = 1'b0;
        n_checks++; if (state !== 3'd0) begin n_err++; $display("FAIL stray_done got %0d want 0", state); end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) btn_enter = ~btn_enter;
            if (btn_clear) btn_clear = ($urandom_range(0, 2) != 0);
            else           btn_clear = ($urandom_range(0, 40) == 0);
            alu_done = ($urandom_range(0, 11) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            sw       = WIDTH'($urandom);
            step();
            n_checks++;
            if (state !== 3'(m_state) || op_a !== WIDTH'(m_a) || op_b !== WIDTH'(m_b) ||
                opcode !== OPW'(m_op) || start !== 1'(m_start) || timeout_err !== 1'(m_err)) begin
                n_err++;
                if (bad < 10)
                    $display("FAIL random_cyc%0d got st%0d a%0h b%0h op%0h s%0b e%0b want st%0d a%0h b%0h op%0h s%0b e%0b",
                             i, state, op_a, op_b, opcode, start, timeout_err,
                             m_state, m_a, m_b, m_op, m_start, m_err);
                bad++;
            end
        end
        rst = 1'b0; btn_enter = 1'b0; btn_clear = 1'b0; alu_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn_enter = 1'b0; btn_clear = 1'b0; alu_done = 1'b0; sw = '0;
        test_reset();
        test_full_sequence();
        test_hold_enter();
        test_timeout();
        test_enter_clear_same();
        test_done_with_start();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
